// File: rtl/ex_stage.sv
// EX stage of the 16-bit MIPS core: ALU, branch target, destination select, EX/MEM register.
// Define EX_MUL_EN to build the multi-cycle shift-add multiply (funct 110); otherwise funct 110 is illegal.
module ex_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              mem_stall,
    input  logic [DATA_W-1:0] in_PC_plus_two,
    input  logic [DATA_W-1:0] in_Read_data_1,
    input  logic [DATA_W-1:0] in_Read_data_2,
    input  logic [DATA_W-1:0] in_immediate,
    input  logic              in_ALU_Src,
    input  logic [1:0]        in_ALUOp,
    input  logic              in_RegDest,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_MemRead,
    input  logic              in_MemWrite,
    input  logic              in_Branch,
    input  logic              in_MemtoReg,
    input  logic              in_RegWrite,
    output logic              O_valid,
    output logic [DATA_W-1:0] O_alu_result,
    output logic              O_zero,
    output logic [DATA_W-1:0] O_branch_target,
    output logic [DATA_W-1:0] O_write_data,
    output logic [REG_W-1:0]  O_write_reg,
    output logic              O_MemRead,
    output logic              O_MemWrite,
    output logic              O_Branch,
    output logic              O_MemtoReg,
    output logic              O_RegWrite,
    output logic              O_illegal
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] alu;
        logic              zero;
        logic [DATA_W-1:0] target;
        logic [DATA_W-1:0] wdata;
        logic [REG_W-1:0]  wreg;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              mem_to_reg;
        logic              reg_write;
        logic              illegal;
    } exmem_t;

    logic [DATA_W-1:0] op_b_s;
    logic [DATA_W-1:0] alu_res_s;
    logic              illegal_s;
    logic              accept_s;
    exmem_t            single_s;
    exmem_t            exmem_nxt_s;
    exmem_t            exmem_r;

`ifdef EX_MUL_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] mcand_r;
    logic [DATA_W-1:0] mplier_r;
    logic [DATA_W-1:0] prod_r;
    exmem_t            mul_ctl_r;
    exmem_t            mul_out_s;
    logic              is_mul_s;

    assign in_ready = rst_n && (state_r == ST_IDLE) && !mem_stall;
`else
    assign in_ready = rst_n && !mem_stall;
`endif

    assign accept_s = in_valid && in_ready && !flush;

    // Operand select and ALU decode
    always_comb begin
        op_b_s    = in_ALU_Src ? in_immediate : in_Read_data_2;
        alu_res_s = {DATA_W{1'b0}};
        illegal_s = 1'b0;
`ifdef EX_MUL_EN
        is_mul_s  = 1'b0;
`endif
        case (in_ALUOp)
            2'b00: alu_res_s = in_Read_data_1 + op_b_s;
            2'b01: alu_res_s = in_Read_data_1 - op_b_s;
            2'b10: begin
                case (in_immediate[2:0])
                    3'b000: alu_res_s = in_Read_data_1 + op_b_s;
                    3'b001: alu_res_s = in_Read_data_1 - op_b_s;
                    3'b010: alu_res_s = in_Read_data_1 & op_b_s;
                    3'b011: alu_res_s = in_Read_data_1 | op_b_s;
                    3'b100: alu_res_s = {{(DATA_W-1){1'b0}},
                                         ($signed(in_Read_data_1) < $signed(op_b_s))};
                    3'b101: alu_res_s = in_Read_data_1 << op_b_s[3:0];
`ifdef EX_MUL_EN
                    3'b110: is_mul_s  = 1'b1;
`else
                    3'b110: illegal_s = 1'b1;
`endif
                    default: illegal_s = 1'b1;
                endcase
            end
            2'b11: alu_res_s = in_Read_data_1 | op_b_s;
            default: alu_res_s = {DATA_W{1'b0}};
        endcase
    end

    // EX/MEM payload of a single-cycle instruction; illegal ops never write state
    always_comb begin
        single_s            = '0;
        single_s.valid      = 1'b1;
        single_s.alu        = alu_res_s;
        single_s.zero       = (alu_res_s == {DATA_W{1'b0}});
        single_s.target     = in_PC_plus_two + {in_immediate[DATA_W-2:0], 1'b0};
        single_s.wdata      = in_Read_data_2;
        single_s.wreg       = in_RegDest ? in_rd : in_rt;
        single_s.mem_read   = in_MemRead && !illegal_s;
        single_s.mem_write  = in_MemWrite && !illegal_s;
        single_s.branch     = in_Branch;
        single_s.mem_to_reg = in_MemtoReg;
        single_s.reg_write  = in_RegWrite && !illegal_s;
        single_s.illegal    = illegal_s;
    end

    // Next EX/MEM contents; anything not producing a result becomes a bubble
    always_comb begin
        exmem_nxt_s = '0;
        if (flush) begin
            exmem_nxt_s = '0;
`ifdef EX_MUL_EN
        end else if (state_r == ST_DONE) begin
            exmem_nxt_s = mul_out_s;
        end else if (accept_s && !is_mul_s) begin
            exmem_nxt_s = single_s;
`else
        end else if (accept_s) begin
            exmem_nxt_s = single_s;
`endif
        end else begin
            exmem_nxt_s = '0;
        end
    end

    // EX/MEM register, frozen while memory stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exmem_r <= '0;
        end else if (!mem_stall) begin
            exmem_r <= exmem_nxt_s;
        end else begin
            exmem_r <= exmem_r;
        end
    end

`ifdef EX_MUL_EN
    // Product result carrying the controls captured at accept
    always_comb begin
        mul_out_s         = mul_ctl_r;
        mul_out_s.valid   = 1'b1;
        mul_out_s.alu     = prod_r;
        mul_out_s.zero    = (prod_r == {DATA_W{1'b0}});
        mul_out_s.illegal = 1'b0;
    end

    // Multiply FSM next state; flush aborts regardless of mem_stall
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && is_mul_s) state_nxt_s = ST_MUL;
                else                      state_nxt_s = ST_IDLE;
            end
            ST_MUL: begin
                if (flush)                 state_nxt_s = ST_IDLE;
                else if (cnt_r == CNT_LAST) state_nxt_s = ST_DONE;
                else                       state_nxt_s = ST_MUL;
            end
            ST_DONE: begin
                if (flush || !mem_stall) state_nxt_s = ST_IDLE;
                else                     state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_nxt_s;
    end

    // Shift-add datapath: one multiplier bit per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= {CNT_W{1'b0}};
            mcand_r   <= {DATA_W{1'b0}};
            mplier_r  <= {DATA_W{1'b0}};
            prod_r    <= {DATA_W{1'b0}};
            mul_ctl_r <= '0;
        end else if (flush) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && is_mul_s) begin
                        mcand_r   <= in_Read_data_1;
                        mplier_r  <= op_b_s;
                        prod_r    <= {DATA_W{1'b0}};
                        cnt_r     <= {CNT_W{1'b0}};
                        mul_ctl_r <= single_s;
                    end
                end
                ST_MUL: begin
                    if (mplier_r[0]) prod_r <= prod_r + mcand_r;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + CNT_W'(1);
                end
                default: cnt_r <= cnt_r;
            endcase
        end
    end
`endif

    assign O_valid         = exmem_r.valid;
    assign O_alu_result    = exmem_r.alu;
    assign O_zero          = exmem_r.zero;
    assign O_branch_target = exmem_r.target;
    assign O_write_data    = exmem_r.wdata;
    assign O_write_reg     = exmem_r.wreg;
    assign O_MemRead       = exmem_r.mem_read;
    assign O_MemWrite      = exmem_r.mem_write;
    assign O_Branch        = exmem_r.branch;
    assign O_MemtoReg      = exmem_r.mem_to_reg;
    assign O_RegWrite      = exmem_r.reg_write;
    assign O_illegal       = exmem_r.illegal;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized traffic against an arithmetic model.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, mem_stall;
    logic [15:0] in_PC_plus_two, in_Read_data_1, in_Read_data_2, in_immediate;
    logic        in_ALU_Src;
    logic [1:0]  in_ALUOp;
    logic        in_RegDest;
    logic [2:0]  in_rt, in_rd;
    logic        in_MemRead, in_MemWrite, in_Branch, in_MemtoReg, in_RegWrite;
    logic        O_valid, O_zero;
    logic [15:0] O_alu_result, O_branch_target, O_write_data;
    logic [2:0]  O_write_reg;
    logic        O_MemRead, O_MemWrite, O_Branch, O_MemtoReg, O_RegWrite, O_illegal;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        valid;
        logic [15:0] alu;
        logic        zero;
        logic [15:0] tgt;
        logic [15:0] wd;
        logic [2:0]  wr;
        logic        mr, mw, br, m2r, rw, ill;
    } exp_t;

    ex_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .mem_stall(mem_stall),
        .in_PC_plus_two(in_PC_plus_two), .in_Read_data_1(in_Read_data_1),
        .in_Read_data_2(in_Read_data_2), .in_immediate(in_immediate),
        .in_ALU_Src(in_ALU_Src), .in_ALUOp(in_ALUOp), .in_RegDest(in_RegDest),
        .in_rt(in_rt), .in_rd(in_rd), .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite),
        .in_Branch(in_Branch), .in_MemtoReg(in_MemtoReg), .in_RegWrite(in_RegWrite),
        .O_valid(O_valid), .O_alu_result(O_alu_result), .O_zero(O_zero),
        .O_branch_target(O_branch_target), .O_write_data(O_write_data),
        .O_write_reg(O_write_reg), .O_MemRead(O_MemRead), .O_MemWrite(O_MemWrite),
        .O_Branch(O_Branch), .O_MemtoReg(O_MemtoReg), .O_RegWrite(O_RegWrite),
        .O_illegal(O_illegal)
    );

    always #5 clk = ~clk;

    // Reference behaviour of one accepted instruction, from plain integer arithmetic
    function automatic exp_t model(input logic [15:0] pc, a, rd2, imm, input logic src,
                                   input logic [1:0] op, input logic rdest,
                                   input logic [2:0] rt, rd, input logic [4:0] ctl);
        exp_t   e;
        longint ia, ib, r, sa, sb, t;
        logic   ill;
        ia = a;
        ib = src ? imm : rd2;
        ill = 1'b0;
        r = 0;
        case (op)
            2'd0: r = ia + ib;
            2'd1: r = ia - ib;
            2'd3: r = ia | ib;
            default: begin
                case (imm[2:0])
                    3'd0: r = ia + ib;
                    3'd1: r = ia - ib;
                    3'd2: r = ia & ib;
                    3'd3: r = ia | ib;
                    3'd4: begin
                        sa = (ia >= 32768) ? ia - 65536 : ia;
                        sb = (ib >= 32768) ? ib - 65536 : ib;
                        r = (sa < sb) ? 1 : 0;
                    end
                    3'd5: r = ia << (ib % 16);
`ifdef EX_MUL_EN
                    3'd6: r = ia * ib;
`endif
                    default: ill = 1'b1;
                endcase
            end
        endcase
        r = r & 65535;
        t = (longint'(pc) + 2 * longint'(imm)) & 65535;
        e.valid = 1'b1;
        e.alu   = r[15:0];
        e.zero  = (r == 0);
        e.tgt   = t[15:0];
        e.wd    = rd2;
        e.wr    = rdest ? rd : rt;
        e.mr    = ctl[4] & ~ill;
        e.mw    = ctl[3] & ~ill;
        e.br    = ctl[2];
        e.m2r   = ctl[1];
        e.rw    = ctl[0] & ~ill;
        e.ill   = ill;
        return e;
    endfunction

    function automatic exp_t observed();
        return {O_valid, O_alu_result, O_zero, O_branch_target, O_write_data, O_write_reg,
                O_MemRead, O_MemWrite, O_Branch, O_MemtoReg, O_RegWrite, O_illegal};
    endfunction

    function automatic logic [6:0] ctl_bits(input exp_t e);
        return {e.valid, e.mr, e.mw, e.br, e.m2r, e.rw, e.ill};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        in_valid = 1'b0; flush = 1'b0; mem_stall = 1'b0;
        in_PC_plus_two = 16'h0; in_Read_data_1 = 16'h0; in_Read_data_2 = 16'h0;
        in_immediate = 16'h0; in_ALU_Src = 1'b0; in_ALUOp = 2'b00; in_RegDest = 1'b0;
        in_rt = 3'd0; in_rd = 3'd0;
        {in_MemRead, in_MemWrite, in_Branch, in_MemtoReg, in_RegWrite} = 5'b00000;
    endtask

    task automatic drive(input logic [15:0] pc, a, rd2, imm, input logic src,
                         input logic [1:0] op, input logic rdest, input logic [2:0] rt, rd,
                         input logic [4:0] ctl);
        in_valid = 1'b1;
        in_PC_plus_two = pc; in_Read_data_1 = a; in_Read_data_2 = rd2; in_immediate = imm;
        in_ALU_Src = src; in_ALUOp = op; in_RegDest = rdest; in_rt = rt; in_rd = rd;
        {in_MemRead, in_MemWrite, in_Branch, in_MemtoReg, in_RegWrite} = ctl;
    endtask

    task automatic test_reset();
        drive(16'h0042, 16'h0007, 16'h0009, 16'h0001, 1'b1, 2'b00, 1'b1, 3'd1, 3'd6, 5'b00011);
        tick();
        set_idle();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (observed() !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 0", observed());
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: got %b expected 0", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL release_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_add_imm();
        exp_t e;
        drive(16'h0000, 16'h0010, 16'h0000, 16'hFFFF, 1'b1, 2'b00, 1'b0, 3'd3, 3'd5, 5'b00001);
        e = model(16'h0000, 16'h0010, 16'h0000, 16'hFFFF, 1'b1, 2'b00, 1'b0, 3'd3, 3'd5, 5'b00001);
        tick();
        set_idle();
        total++;
        if (O_alu_result !== 16'h000F || O_write_reg !== 3'd3 || O_valid !== 1'b1) begin
            bad++;
            $display("FAIL add_imm: got res=%h wr=%0d v=%b expected res=000f wr=3 v=1",
                     O_alu_result, O_write_reg, O_valid);
        end
        total++;
        if (observed() !== e) begin
            bad++;
            $display("FAIL add_imm_all: got %h expected %h", observed(), e);
        end
    endtask

    task automatic test_beq();
        drive(16'h0100, 16'h1234, 16'h1234, 16'h0004, 1'b0, 2'b01, 1'b0, 3'd2, 3'd0, 5'b00100);
        tick();
        set_idle();
        total++;
        if (O_zero !== 1'b1 || O_branch_target !== 16'h0108 || O_Branch !== 1'b1) begin
            bad++;
            $display("FAIL beq: got zero=%b tgt=%h br=%b expected zero=1 tgt=0108 br=1",
                     O_zero, O_branch_target, O_Branch);
        end
    endtask

    task automatic test_slt_wrap();
        drive(16'h0000, 16'h8000, 16'h0001, 16'h0004, 1'b0, 2'b10, 1'b1, 3'd0, 3'd4, 5'b00001);
        tick();
        total++;
        if (O_alu_result !== 16'h0001) begin
            bad++;
            $display("FAIL slt_signed: got %h expected 0001", O_alu_result);
        end
        drive(16'h0000, 16'hFFFF, 16'h0002, 16'h0000, 1'b0, 2'b10, 1'b1, 3'd0, 3'd4, 5'b00001);
        tick();
        set_idle();
        total++;
        if (O_alu_result !== 16'h0001 || O_zero !== 1'b0) begin
            bad++;
            $display("FAIL add_wrap: got %h zero=%b expected 0001 zero=0", O_alu_result, O_zero);
        end
    endtask

    task automatic test_stall();
        exp_t ea, eb;
        drive(16'h0200, 16'h00F0, 16'h0F0F, 16'h0002, 1'b0, 2'b10, 1'b1, 3'd1, 3'd7, 5'b01000);
        ea = model(16'h0200, 16'h00F0, 16'h0F0F, 16'h0002, 1'b0, 2'b10, 1'b1, 3'd1, 3'd7, 5'b01000);
        tick();
        drive(16'h0300, 16'h0003, 16'h0005, 16'h0005, 1'b0, 2'b10, 1'b0, 3'd6, 3'd2, 5'b00001);
        eb = model(16'h0300, 16'h0003, 16'h0005, 16'h0005, 1'b0, 2'b10, 1'b0, 3'd6, 3'd2, 5'b00001);
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_ready[%0d]: got %b expected 0", i, in_ready);
            end
            tick();
            total++;
            if (observed() !== ea) begin
                bad++;
                $display("FAIL stall_hold[%0d]: got %h expected %h", i, observed(), ea);
            end
        end
        mem_stall = 1'b0;
        tick();
        set_idle();
        total++;
        if (observed() !== eb) begin
            bad++;
            $display("FAIL stall_release: got %h expected %h", observed(), eb);
        end
    endtask

    task automatic test_flush();
        drive(16'h0000, 16'h0001, 16'h0001, 16'h0000, 1'b0, 2'b00, 1'b0, 3'd1, 3'd1, 5'b11111);
        flush = 1'b1;
        tick();
        set_idle();
        total++;
        if (ctl_bits(observed()) !== 7'b0) begin
            bad++;
            $display("FAIL flush_bubble: got ctl=%b expected 0000000", ctl_bits(observed()));
        end
    endtask

    task automatic test_illegal();
        drive(16'h0000, 16'h1111, 16'h2222, 16'h0007, 1'b0, 2'b10, 1'b1, 3'd0, 3'd3, 5'b11111);
        tick();
        set_idle();
        total++;
        if ({O_valid, O_illegal, O_RegWrite, O_MemRead, O_MemWrite, O_Branch, O_MemtoReg}
            !== 7'b1100011) begin
            bad++;
            $display("FAIL illegal: got v/ill/rw/mr/mw/br/m2r=%b expected 1100011",
                     {O_valid, O_illegal, O_RegWrite, O_MemRead, O_MemWrite, O_Branch, O_MemtoReg});
        end
    endtask

`ifdef EX_MUL_EN
    task automatic test_mul();
        int   low;
        exp_t e;
        logic [15:0] a, b;
        drive(16'h0000, 16'h0123, 16'h0045, 16'h0006, 1'b0, 2'b10, 1'b1, 3'd0, 3'd5, 5'b00001);
        tick();
        set_idle();
        low = 0;
        while (in_ready === 1'b0 && low < 40) begin
            total++;
            if (O_valid !== 1'b0) begin
                bad++;
                $display("FAIL mul_busy_valid[%0d]: got %b expected 0", low, O_valid);
            end
            low++;
            tick();
        end
        total++;
        if (low != 17) begin
            bad++;
            $display("FAIL mul_latency: got %0d busy cycles expected 17", low);
        end
        total++;
        if (O_valid !== 1'b1 || O_alu_result !== 16'h4E6F || O_write_reg !== 3'd5 || O_RegWrite !== 1'b1) begin
            bad++;
            $display("FAIL mul_result: got v=%b res=%h wr=%0d rw=%b expected v=1 res=4e6f wr=5 rw=1",
                     O_valid, O_alu_result, O_write_reg, O_RegWrite);
        end
        a = 16'($urandom);
        b = 16'($urandom);
        e = model(16'h0010, a, b, 16'h0006, 1'b0, 2'b10, 1'b0, 3'd2, 3'd0, 5'b00011);
        drive(16'h0010, a, b, 16'h0006, 1'b0, 2'b10, 1'b0, 3'd2, 3'd0, 5'b00011);
        tick();
        set_idle();
        mem_stall = 1'b1;
        repeat (20) tick();
        total++;
        if (in_ready !== 1'b0 || O_valid !== 1'b0) begin
            bad++;
            $display("FAIL mul_done_wait: got rdy=%b v=%b expected 0 0", in_ready, O_valid);
        end
        mem_stall = 1'b0;
        tick();
        total++;
        if (observed() !== e) begin
            bad++;
            $display("FAIL mul_after_stall: got %h expected %h", observed(), e);
        end
    endtask

    task automatic test_mul_flush();
        drive(16'h0000, 16'h0007, 16'h0003, 16'h0006, 1'b0, 2'b10, 1'b0, 3'd1, 3'd0, 5'b00001);
        tick();
        set_idle();
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++;
        if (in_ready !== 1'b1 || O_valid !== 1'b0) begin
            bad++;
            $display("FAIL mul_flush: got rdy=%b v=%b expected 1 0", in_ready, O_valid);
        end
        repeat (20) tick();
        total++;
        if (O_valid !== 1'b0) begin
            bad++;
            $display("FAIL mul_flush_no_result: got v=%b expected 0", O_valid);
        end
    endtask
`else
    task automatic test_mul_disabled();
        drive(16'h0000, 16'h0123, 16'h0045, 16'h0006, 1'b0, 2'b10, 1'b1, 3'd0, 3'd5, 5'b00001);
        tick();
        set_idle();
        #1;
        total++;
        if ({O_valid, O_illegal, O_RegWrite, in_ready} !== 4'b1101) begin
            bad++;
            $display("FAIL mul_disabled: got v/ill/rw/rdy=%b expected 1101",
                     {O_valid, O_illegal, O_RegWrite, in_ready});
        end
    endtask
`endif

    task automatic test_random();
        exp_t        cur, e;
        logic [15:0] pc, a, b, imm;
        logic        src, rdest, vld, fl, st;
        logic [1:0]  op;
        logic [2:0]  rt, rd;
        logic [4:0]  ctl;
        cur = '0;
        for (int i = 0; i < 300; i++) begin
            pc = 16'($urandom); a = 16'($urandom); b = 16'($urandom); imm = 16'($urandom);
            src = 1'($urandom); op = 2'($urandom); rdest = 1'($urandom);
            rt = 3'($urandom); rd = 3'($urandom); ctl = 5'($urandom);
            if (op == 2'b10 && imm[2:0] == 3'b110) imm[0] = 1'b1;
            if ($urandom_range(0, 3) == 0) a = 16'h8000 | 16'($urandom_range(0, 3));
            vld = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 9) == 0);
            st  = (i == 0) ? 1'b0 : ($urandom_range(0, 4) == 0);
            drive(pc, a, b, imm, src, op, rdest, rt, rd, ctl);
            in_valid = vld; flush = fl; mem_stall = st;
            #1;
            total++;
            if (in_ready !== !st) begin
                bad++;
                $display("FAIL rnd_ready[%0d]: got %b expected %b", i, in_ready, !st);
            end
            if (!st) begin
                e = model(pc, a, b, imm, src, op, rdest, rt, rd, ctl);
                cur = (vld && !fl) ? e : '0;
            end
            tick();
            total++;
            if (ctl_bits(observed()) !== ctl_bits(cur)) begin
                bad++;
                $display("FAIL rnd_ctl[%0d]: got %b expected %b", i, ctl_bits(observed()), ctl_bits(cur));
            end
            if (cur.valid && !cur.ill) begin
                total++;
                if (observed() !== cur) begin
                    bad++;
                    $display("FAIL rnd_data[%0d]: got %h expected %h", i, observed(), cur);
                end
            end
        end
        set_idle();
        tick();
    endtask

    initial begin
        set_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_add_imm();
        test_beq();
        test_slt_wrap();
        test_stall();
        test_flush();
        test_illegal();
`ifdef EX_MUL_EN
        test_mul();
        test_mul_flush();
`else
        test_mul_disabled();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
